// File: rtl/output_port_queue.sv
// rtl/output_port_queue.sv - per-direction router output FIFO with wormhole lock
module output_port_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_flit,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       lock,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_flit,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q, state_d;
    logic            push, pop;

    // No full-bypass: a pop in the same cycle does not reopen in_ready.
    assign in_ready  = (count_q != FULL) && !rst;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_flit  = mem_q[rd_ptr_q][WIDTH-1:0];
    assign out_last  = mem_q[rd_ptr_q][WIDTH];
    assign count     = count_q;
    assign lock      = (state_q == BUSY);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push && !in_last) state_d = BUSY;
            BUSY:    if (push && in_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage is not reset; flits are only visible through count/pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_last, in_flit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end
endmodule

// File: tb/tb_output_port_queue.sv
// tb/tb_output_port_queue.sv - directed self-checking bench for output_port_queue
module tb_output_port_queue;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic [WIDTH-1:0]           in_flit;
    logic                       in_last;
    logic                       in_ready;
    logic                       lock;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_flit;
    logic                       out_last;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] count;

    int checks = 0;
    int errors = 0;

    output_port_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_flit(in_flit), .in_last(in_last), .in_ready(in_ready),
        .lock(lock),
        .out_valid(out_valid), .out_flit(out_flit), .out_last(out_last), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] f, input logic l);
        in_valid = v;
        in_flit  = f;
        in_last  = l;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, 1'b0);

        // 1: reset and single flit
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_lock", lock, 0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        drive(1'b1, 16'h00A5, 1'b1);
        step();
        check("single_valid", out_valid, 1);
        check("single_flit", out_flit, 16'h00A5);
        check("single_last", out_last, 1);
        check("single_count1", count, 1);
        check("single_lock", lock, 0);
        drive(1'b0, '0, 1'b0);
        step();
        check("single_count0", count, 0);
        check("single_empty", out_valid, 0);
        check("single_lock2", lock, 0);

        // 2: fill and backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, WIDTH'(i), 1'b1);
            check("fill_ready", in_ready, 1);
            step();
            check("fill_count", count, i);
        end
        check("full_in_ready", in_ready, 0);
        drive(1'b1, 16'h0005, 1'b1);
        step();
        check("full_hold_count", count, 4);
        check("full_hold_ready", in_ready, 0);
        check("full_head", out_flit, 16'h0001);
        out_ready = 1'b1;
        #1;
        check("full_no_bypass", in_ready, 0);
        step();
        check("bp_ready_back", in_ready, 1);
        check("bp_count3", count, 3);
        check("bp_order2", out_flit, 16'h0002);
        step();
        check("bp_order3", out_flit, 16'h0003);
        check("bp_count_pp", count, 3);
        drive(1'b0, '0, 1'b0);
        step();
        check("bp_order4", out_flit, 16'h0004);
        step();
        check("bp_order5", out_flit, 16'h0005);
        check("bp_count1", count, 1);
        step();
        check("bp_drained", out_valid, 0);

        // 3: wormhole lock
        drive(1'b1, 16'h0010, 1'b0);
        check("lock_before", lock, 0);
        step();
        check("lock_head", lock, 1);
        drive(1'b1, 16'h0011, 1'b0);
        step();
        check("lock_body", lock, 1);
        drive(1'b1, 16'h0012, 1'b1);
        check("lock_tail_cycle", lock, 1);
        step();
        check("lock_released", lock, 0);
        check("lock_tail_flit", out_flit, 16'h0012);
        check("lock_tail_last", out_last, 1);
        drive(1'b0, '0, 1'b0);
        step();
        check("lock_drain", count, 0);

        // 4: streaming with pointer wraps
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, WIDTH'(i), 1'b1);
            check("stream_ready", in_ready, 1);
            step();
            check("stream_flit", out_flit, i);
            check("stream_count", count, 1);
        end
        drive(1'b0, '0, 1'b0);
        step();
        check("stream_drain", count, 0);

        // 5: simultaneous push/pop at count 2
        out_ready = 1'b0;
        drive(1'b1, 16'h0030, 1'b1);
        step();
        drive(1'b1, 16'h0031, 1'b1);
        step();
        check("mid_count2", count, 2);
        out_ready = 1'b1;
        drive(1'b1, 16'h0032, 1'b1);
        check("mid_head", out_flit, 16'h0030);
        step();
        check("mid_count_kept", count, 2);
        check("mid_order1", out_flit, 16'h0031);
        drive(1'b0, '0, 1'b0);
        step();
        check("mid_order2", out_flit, 16'h0032);
        step();
        check("mid_drain", count, 0);

        // 6: reset mid-packet
        out_ready = 1'b0;
        drive(1'b1, 16'h0040, 1'b0);
        step();
        check("mrst_lock", lock, 1);
        check("mrst_count", count, 1);
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        #1;
        check("mrst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("mrst_lock0", lock, 0);
        check("mrst_count0", count, 0);
        check("mrst_valid0", out_valid, 0);
        out_ready = 1'b1;
        drive(1'b1, 16'h0041, 1'b1);
        step();
        check("mrst_fresh_flit", out_flit, 16'h0041);
        check("mrst_fresh_count", count, 1);
        check("mrst_fresh_lock", lock, 0);
        drive(1'b0, '0, 1'b0);
        step();
        check("mrst_fresh_drain", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_port_queue.md
# output_port_queue

Per-direction output stage of the mesh router: consumes flits already granted by the round-robin arbiter and switched through the crossbar, buffers them in a small FIFO, and drives the valid/ready link into the neighbouring router's input stage (or the core). It also holds a wormhole `lock` so the arbiter keeps its grant on one source until that packet's tail flit has been accepted. One instance exists per output direction: north, east, south, west and core.

## Interface
- `WIDTH`, default 64: flit payload width in bits.
- `DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.

- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  crossbar presents a flit.
- `in_flit`  input  WIDTH  flit payload.
- `in_last`  input  1  flit is the tail of its packet; single-flit packets set it on the head.
- `in_ready`  output  1  queue accepts a flit this cycle.
- `lock`  output  1  packet in progress; the arbiter must not re-arbitrate this output.
- `out_valid`  output  1  flit available toward the neighbour.
- `out_flit`  output  WIDTH  head-of-queue payload.
- `out_last`  output  1  head-of-queue tail marker.
- `out_ready`  input  1  neighbour input stage accepts.
- `count`  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
**Handshakes**
- Push occurs when `in_valid && in_ready`.
- Pop occurs when `out_valid && out_ready`.
- Storage is `DEPTH` entries of {`last`, `flit`}, with write pointer, read pointer and `count`.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH` naturally.

**Output equations**
- `in_ready` = (`count` != `DEPTH`) && !`rst`.
- There is no full-bypass: while full, `in_ready` stays 0 even if a pop occurs in the same cycle.
- `out_valid` = (`count` != 0).
- `out_flit` and `out_last` are the storage entry at the read pointer.
- There is no empty-bypass: `in_*` has no combinational path to `out_*`.

**Count update**
- Push only: +1.
- Pop only: −1.
- Push and pop together (possible whenever 0 < `count` < `DEPTH`): unchanged, both pointers advance.

**Producer rule**
- While `in_valid && !in_ready`, the producer holds `in_flit` and `in_last` stable.
- The queue never drops or duplicates a flit.

**Consumer guarantee**
- While `out_valid && !out_ready`, `out_flit` and `out_last` stay stable.

**Lock FSM**
- Two states: IDLE and BUSY.
- IDLE → BUSY on a push with `in_last`=0.
- BUSY → IDLE on a push with `in_last`=1.
- All other cycles hold state. A single-flit packet pushed in IDLE stays IDLE.
- `lock` = (state == BUSY), registered.
- The arbiter samples `lock` to keep the current grant.

**Reset**
- `rst` high at an edge clears both pointers and `count`, and sets the FSM to IDLE. This applies mid-packet as well.
- All buffered flits are discarded; storage contents need no reset.
- While `rst` is high, `in_ready` is 0.

## Timing
- Output values during and immediately after reset: `out_valid`=0, `count`=0, `lock`=0, `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Latency: a flit pushed at edge N shows `out_valid`=1 in cycle N+1 (one cycle, minimum).
- Throughput: one flit per cycle sustained when `out_ready` is held high, including steady state with `count`=1.
- `lock` rises in the cycle after a non-tail push and falls in the cycle after the tail push.
- Between packets the arbiter may therefore switch sources at the earliest on the cycle after the tail is accepted.
- Full: `count`==`DEPTH` gives `in_ready`=0 the same cycle `count` reaches `DEPTH`; it returns to 1 the cycle after the first pop.
- Empty: `count`==0 gives `out_valid`=0. A pop is impossible; `out_ready` is ignored.
- Boundary case: the read-pointer wrap from `DEPTH`−1 to 0 must not disturb `out_flit`.

## Test plan
1. **Reset and single flit.**
   - Stimulus: reset 2 cycles, then push flit 0xA5 with `last`=1 and `out_ready`=1.
   - Required: `out_valid` rises exactly 1 cycle later with `out_flit`=0xA5, `lock` never asserts, and `count` goes 0→1→0.
2. **Fill and backpressure.**
   - Stimulus: `out_ready`=0, push 5 flits 0x1..0x5 back-to-back with `DEPTH`=4.
   - Required: 0x1..0x4 accepted, `in_ready`=0 at `count`=4, and 0x5 held.
   - Then release `out_ready`: output order is 0x1..0x5 and `in_ready` returns the cycle after the first pop.
3. **Wormhole lock.**
   - Stimulus: push head 0x10 (`last`=0), body 0x11 (`last`=0), tail 0x12 (`last`=1).
   - Required: `lock` high from the cycle after the 0x10 push through the cycle of the 0x12 push, and low the cycle after.
4. **Streaming with wrap.**
   - Stimulus: `out_ready`=1, push 20 consecutive flits 0..19.
   - Required: one pop per cycle, `count` steady at 1, and the output sequence 0..19 in order, covering five pointer wraps.
5. **Simultaneous push and pop at mid-occupancy.**
   - Stimulus: with `count`=2, push and pop in the same cycle.
   - Required: `count` stays 2 and FIFO order is preserved.
6. **Reset mid-packet.**
   - Stimulus: after pushing a head flit (`lock`=1, `count`=1), assert `rst` for 1 cycle.
   - Required: next cycle `lock`=0, `count`=0, `out_valid`=0, and subsequent pushes behave as from a fresh reset.
